// File: rtl/robo_pkg.sv
// Shared types and constants for the maze robot mission sequencer.
// Used by the controller RTL and by the bench.
package robo_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FOLLOW,
        S_REMOVE,
        S_DONE,
        S_TIMEOUT
    } state_t;

    // Heading codes: north, south, leste (east), oeste (west)
    typedef enum logic [1:0] {
        DIR_N = 2'b00,
        DIR_S = 2'b01,
        DIR_L = 2'b10,
        DIR_O = 2'b11
    } dir_t;

    typedef logic [2:0] cmd_t;

    localparam cmd_t CMD_NONE    = 3'b000;
    localparam cmd_t CMD_AVANCAR = 3'b001;
    localparam cmd_t CMD_GIRAR   = 3'b010;
    localparam cmd_t CMD_REMOVER = 3'b100;

    // Heading after one girar (90 deg counter-clockwise)
    function automatic dir_t turn_ccw(input dir_t d);
        dir_t r;
        r = DIR_N;
        case (d)
            DIR_N:   r = DIR_O;
            DIR_O:   r = DIR_S;
            DIR_S:   r = DIR_L;
            default: r = DIR_N;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/robo_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear and increment together load the value 1.
module robo_sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= W'(inc);
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/robo_mission_ctrl.sv
// Left-wall-following mission sequencer with barrier removal,
// home detection and a move budget.
module robo_mission_ctrl
    import robo_pkg::*;
#(
    parameter int MOVE_W        = 8,
    parameter int MAX_MOVES     = 200,
    parameter int MIN_MOVES     = 4,
    parameter int REMOVE_CYCLES = 3,
    parameter int MAX_REMOVALS  = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              head,
    input  logic              left,
    input  logic              under,
    input  logic              barrier,
    output logic              avancar,
    output logic              girar,
    output logic              remover,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [MOVE_W-1:0] move_count,
    output logic [3:0]        remove_count
);

    localparam int REM_W = $clog2(REMOVE_CYCLES + 1);

    state_t     state, state_nx;
    cmd_t       cmd, cmd_nx;
    logic       pend_adv, pend_nx;
    logic       mv_clr, mv_inc;
    logic       rm_clr, rm_inc;
    logic       rc_clr, rc_inc;
    logic [REM_W-1:0] rem_cnt;

    logic at_max, home, take_barrier, rem_last;

    assign at_max       = (move_count == MOVE_W'(MAX_MOVES));
    assign home         = under && (move_count >= MOVE_W'(MIN_MOVES));
    assign take_barrier = barrier && (remove_count < 4'(MAX_REMOVALS));
    assign rem_last     = (rem_cnt == REM_W'(REMOVE_CYCLES));

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            cmd      <= CMD_NONE;
            pend_adv <= 1'b0;
        end else begin
            state    <= state_nx;
            cmd      <= cmd_nx;
            pend_adv <= pend_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cmd_nx   = CMD_NONE;
        pend_nx  = pend_adv;
        mv_clr   = 1'b0;
        mv_inc   = 1'b0;
        rm_clr   = 1'b0;
        rm_inc   = 1'b0;
        rc_clr   = 1'b0;
        rc_inc   = 1'b0;
        unique case (state)
            S_IDLE, S_DONE, S_TIMEOUT: begin
                if (start) begin
                    state_nx = S_FOLLOW;
                    pend_nx  = 1'b0;
                    mv_clr   = 1'b1;
                    rm_clr   = 1'b1;
                    rc_clr   = 1'b1;
                end
            end
            S_FOLLOW: begin
                priority case (1'b1)
                    at_max: begin
                        state_nx = S_TIMEOUT;
                    end
                    home: begin
                        state_nx = S_DONE;
                    end
                    take_barrier: begin
                        state_nx = S_REMOVE;
                        cmd_nx   = CMD_REMOVER;
                        rc_clr   = 1'b1;
                        rc_inc   = 1'b1;
                    end
                    (pend_adv && !head): begin
                        cmd_nx  = CMD_AVANCAR;
                        pend_nx = 1'b0;
                        mv_inc  = 1'b1;
                    end
                    (!pend_adv && !left): begin
                        cmd_nx  = CMD_GIRAR;
                        pend_nx = 1'b1;
                        mv_inc  = 1'b1;
                    end
                    !head: begin
                        cmd_nx = CMD_AVANCAR;
                        mv_inc = 1'b1;
                    end
                    default: begin
                        cmd_nx  = CMD_GIRAR;
                        pend_nx = 1'b0;
                        mv_inc  = 1'b1;
                    end
                endcase
            end
            S_REMOVE: begin
                // rem_cnt counts remover cycles already driven
                if (rem_last) begin
                    state_nx = S_FOLLOW;
                    rm_inc   = 1'b1;
                end else begin
                    cmd_nx = CMD_REMOVER;
                    rc_inc = 1'b1;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    robo_sat_counter #(.W(MOVE_W)) u_move_cnt (
        .clock (clock),
        .reset (reset),
        .clear (mv_clr),
        .inc   (mv_inc),
        .count (move_count)
    );

    robo_sat_counter #(.W(4)) u_remove_cnt (
        .clock (clock),
        .reset (reset),
        .clear (rm_clr),
        .inc   (rm_inc),
        .count (remove_count)
    );

    robo_sat_counter #(.W(REM_W)) u_rem_cycle_cnt (
        .clock (clock),
        .reset (reset),
        .clear (rc_clr),
        .inc   (rc_inc),
        .count (rem_cnt)
    );

    assign avancar = cmd[0];
    assign girar   = cmd[1];
    assign remover = cmd[2];
    assign busy    = (state == S_FOLLOW) || (state == S_REMOVE);
    assign done    = (state == S_DONE);
    assign timeout = (state == S_TIMEOUT);

endmodule

// File: tb/tb_robo_mission_ctrl.sv
// Directed + randomized bench for robo_mission_ctrl with a rule-level
// reference model of the mission sequencer.
module tb_robo_mission_ctrl;

    localparam int MAXM = 20;
    localparam int MINM = 4;
    localparam int RCYC = 3;
    localparam int MAXR = 15;

    localparam int M_IDLE   = 0;
    localparam int M_FOLLOW = 1;
    localparam int M_REM    = 2;
    localparam int M_DONE   = 3;
    localparam int M_TOUT   = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       head = 1'b0;
    logic       left = 1'b0;
    logic       under = 1'b0;
    logic       barrier = 1'b0;
    logic       avancar, girar, remover;
    logic       busy, done, timeout;
    logic [7:0] move_count;
    logic [3:0] remove_count;

    int n_checks = 0;
    int n_errors = 0;

    int m_mode  = M_IDLE;
    int m_moves = 0;
    int m_rems  = 0;
    int m_hold  = 0;
    bit m_pend  = 1'b0;
    bit e_adv   = 1'b0;
    bit e_gir   = 1'b0;
    bit e_rem   = 1'b0;

    robo_mission_ctrl #(
        .MOVE_W        (8),
        .MAX_MOVES     (MAXM),
        .MIN_MOVES     (MINM),
        .REMOVE_CYCLES (RCYC),
        .MAX_REMOVALS  (MAXR)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .head         (head),
        .left         (left),
        .under        (under),
        .barrier      (barrier),
        .avancar      (avancar),
        .girar        (girar),
        .remover      (remover),
        .busy         (busy),
        .done         (done),
        .timeout      (timeout),
        .move_count   (move_count),
        .remove_count (remove_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input bit st, input bit h, input bit l,
                              input bit u, input bit b, input bit rst);
        e_adv = 1'b0;
        e_gir = 1'b0;
        e_rem = 1'b0;
        if (rst) begin
            m_mode  = M_IDLE;
            m_moves = 0;
            m_rems  = 0;
            m_hold  = 0;
            m_pend  = 1'b0;
            return;
        end
        case (m_mode)
            M_FOLLOW: begin
                if (m_moves == MAXM) begin
                    m_mode = M_TOUT;
                end else if (u && m_moves >= MINM) begin
                    m_mode = M_DONE;
                end else if (b && m_rems < MAXR) begin
                    m_mode = M_REM;
                    e_rem  = 1'b1;
                    m_hold = RCYC - 1;
                end else begin
                    if (m_pend && !h) begin
                        e_adv  = 1'b1;
                        m_pend = 1'b0;
                    end else if (!m_pend && !l) begin
                        e_gir  = 1'b1;
                        m_pend = 1'b1;
                    end else if (!h) begin
                        e_adv = 1'b1;
                    end else begin
                        e_gir  = 1'b1;
                        m_pend = 1'b0;
                    end
                    if (m_moves < 255) m_moves++;
                end
            end
            M_REM: begin
                if (m_hold > 0) begin
                    e_rem = 1'b1;
                    m_hold--;
                end else begin
                    m_mode = M_FOLLOW;
                    if (m_rems < 15) m_rems++;
                end
            end
            default: begin
                if (st) begin
                    m_mode  = M_FOLLOW;
                    m_moves = 0;
                    m_rems  = 0;
                    m_pend  = 1'b0;
                end
            end
        endcase
    endtask

    task automatic step(input bit st, input bit h, input bit l,
                        input bit u, input bit b, input bit rst);
        logic [17:0] got, exp;
        start   = st;
        head    = h;
        left    = l;
        under   = u;
        barrier = b;
        reset   = rst;
        @(posedge clock);
        model_edge(st, h, l, u, b, rst);
        #1;
        got = {avancar, girar, remover, busy, done, timeout,
               move_count, remove_count};
        exp = {e_adv, e_gir, e_rem,
               (m_mode == M_FOLLOW) || (m_mode == M_REM),
               m_mode == M_DONE, m_mode == M_TOUT,
               8'(m_moves), 4'(m_rems)};
        check("step_outputs", 32'(got), 32'(exp));
    endtask

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    initial begin
        int n;

        // reset state
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        check("reset_cmds", {avancar, girar, remover}, 0);
        check("reset_status", {busy, done, timeout}, 0);
        check("reset_counts", {move_count, remove_count}, 0);

        // reset during the 2nd remover cycle
        step(1, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 1, 0);
        check("rem_enter", remover, 1);
        step(0, 1, 1, 0, 1, 0);
        check("rem_second", remover, 1);
        step(0, 1, 1, 0, 1, 1);
        check("rst_mid_rem", {remover, busy}, 0);
        check("rst_mid_counts", {move_count, remove_count}, 0);
        step(0, 0, 0, 0, 0, 0);
        check("rst_idle", {busy, done, timeout}, 0);

        // start on the home cell, straight corridor, return at move 12
        step(1, 0, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 1, 0, 0);
            check("home_adv_early", avancar, 1);
        end
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0, 0);
        check("home_moves12", move_count, 12);
        step(0, 0, 1, 1, 0, 0);
        check("home_done", done, 1);
        check("home_done_moves", move_count, 12);
        check("home_no_cmd", {avancar, girar}, 0);

        // left opening from DONE
        step(1, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        check("left_girar", girar, 1);
        step(0, 0, 0, 0, 0, 0);
        check("left_then_adv", {avancar, girar}, 2'b10);

        // dead end: three turns then advance
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 0, 0, 0);
            check("dead_girar", girar, 1);
        end
        check("dead_moves", move_count, 5);
        step(0, 0, 1, 0, 0, 0);
        check("dead_adv", avancar, 1);

        // barrier removal, then exhaust the removal budget
        for (int r = 0; r < 15; r++) begin
            step(0, 1, 1, 0, 1, 0);
            check("bar_rem1", remover, 1);
            step(rb(), rb(), rb(), rb(), rb(), 0);
            check("bar_rem2", remover, 1);
            step(rb(), rb(), rb(), rb(), rb(), 0);
            check("bar_rem3", remover, 1);
            step(rb(), rb(), rb(), 0, rb(), 0);
            check("bar_rem_off", remover, 0);
            check("bar_count", remove_count, r + 1);
            check("bar_moves_kept", move_count, 6);
        end
        step(0, 1, 1, 0, 1, 0);
        check("bar16_girar", {girar, remover}, 2'b10);

        // enclosed loop until the move budget expires
        n = 0;
        while (m_mode != M_TOUT && n < 40) begin
            step(0, rb(), rb(), 0, 0, 0);
            n++;
        end
        check("tout_reached", timeout, 1);
        check("tout_moves", move_count, MAXM);
        for (int i = 0; i < 3; i++) begin
            step(0, rb(), rb(), rb(), rb(), 0);
            check("tout_quiet", {avancar, girar, remover}, 0);
        end
        step(1, 0, 1, 0, 0, 0);
        check("restart_moves", move_count, 0);
        check("restart_busy", busy, 1);

        // randomized missions
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 7) == 0, rb(), rb(),
                 $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 79) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
